cyx_mem_port_arbiter: RTL and testbench

Shares one virtual RAM port between two requesters: requester 0 is the CPU data path and requester 1 is the debug/loader interface. The block arbitrates round-robin, drives the select of the shared-port 2:1 multiplexers, and registers the winner's address, write data and write enable onto the port. It sequences each transaction with a req/ack handshake and aborts on a ready timeout. It sits between the nanoMIPS core/loader and the virtual RAM.

---
 rtl/cyx_mem_port_arbiter_if.sv | 47 ++++
 rtl/cyx_mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_cyx_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cyx_mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared RAM port.
// slave: the arbiter's view. master: the view of whoever drives requests and the port.
interface cyx_mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // requester 0 (CPU data path)
  logic          req0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          we0;
  logic          ack0;
  // requester 1 (debug/loader)
  logic          req1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          we1;
  logic          ack1;
  // shared results
  logic [DW-1:0] rdata;
  logic          err;
  logic          sel;
  logic          busy;
  // shared RAM port
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_rdy;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, addr0, wdata0, we0,
    input  req1, addr1, wdata1, we1,
    input  mem_rdy, mem_rdata,
    output ack0, ack1, rdata, err, sel, busy,
    output mem_req, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, addr0, wdata0, we0,
    output req1, addr1, wdata1, we1,
    output mem_rdy, mem_rdata,
    input  ack0, ack1, rdata, err, sel, busy,
    input  mem_req, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/cyx_mem_port_arbiter.sv
// Two-requester round-robin arbiter for one shared RAM port.
// Grants in IDLE, holds the winner's request on the port during BUSY, and
// pulses ack (with err on ready timeout) for exactly one ACK cycle.
module cyx_mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  cyx_mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } rq_t;

  state_t        r_state;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_err;
  logic [DW-1:0] r_rdata;
  logic          r_busy;

  rq_t           w_rq0;
  rq_t           w_rq1;
  rq_t           w_win_rq;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_tmo;

  assign w_rq0 = '{req: bus.req0, addr: bus.addr0, wdata: bus.wdata0, we: bus.we0};
  assign w_rq1 = '{req: bus.req1, addr: bus.addr1, wdata: bus.wdata1, we: bus.we1};

  // On a tie the requester that did not go last wins; r_last resets to 1 so
  // requester 0 takes the first tie.
  assign w_gnt0   = w_rq0.req & (~w_rq1.req | r_last);
  assign w_gnt1   = w_rq1.req & (~w_rq0.req | ~r_last);
  assign w_win_rq = w_gnt1 ? w_rq1 : w_rq0;
  assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));

  // Transaction sequencer: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_sel       <= w_gnt1;
            r_mem_addr  <= w_win_rq.addr;
            r_mem_wdata <= w_win_rq.wdata;
            r_mem_we    <= w_win_rq.we;
            r_mem_req   <= 1'b1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= BUSY;
          end else begin
            r_mem_req   <= 1'b0;
          end
        end
        BUSY: begin
          // Requester inputs are not looked at here; the port holds the
          // values latched at grant.
          if (bus.mem_rdy || w_tmo) begin
            if (bus.mem_rdy && !r_mem_we) r_rdata <= bus.mem_rdata;
            r_ack0    <= ~r_sel;
            r_ack1    <= r_sel;
            r_err     <= ~bus.mem_rdy;
            r_mem_req <= 1'b0;
            r_last    <= r_sel;
            r_busy    <= 1'b1;
            r_state   <= ACK;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        ACK: begin
          // One-cycle completion; no arbitration so a held req waits for IDLE.
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_ack0    <= 1'b0;
          r_ack1    <= 1'b0;
          r_err     <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_cyx_mem_port_arbiter.sv
// Bench for cyx_mem_port_arbiter: directed phases plus an ack scoreboard.
module tb_cyx_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst_n;

  cyx_mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  cyx_mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_ack = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic e, input logic [DW-1:0] rd);
    exp_t x;
    x.id = id; x.err = e; x.rdata = rd;
    q.push_back(x);
  endtask

  // Scoreboard: every ack pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && (bus.ack0 || bus.ack1)) begin
      exp_t x;
      n_ack++;
      chk("ack_excl", {63'd0, bus.ack0 & bus.ack1}, 64'd0);
      if (q.size() == 0) begin
        chk("sb_unexpected_ack", 64'd1, 64'd0);
      end else begin
        x = q.pop_front();
        chk("sb_id",    {63'd0, bus.ack1}, {63'd0, x.id});
        chk("sb_sel",   {63'd0, bus.sel},  {63'd0, x.id});
        chk("sb_err",   {63'd0, bus.err},  {63'd0, x.err});
        chk("sb_rdata", {32'd0, bus.rdata}, {32'd0, x.rdata});
      end
    end
  end

  initial begin
    int cyc, prev, cnt_req, base;
    logic seen;
    rst_n = 1'b0;
    bus.req0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.we0 = 0;
    bus.req1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.we1 = 0;
    bus.mem_rdy = 0; bus.mem_rdata = '0;
    step(2);
    chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_busy",    {63'd0, bus.busy}, 64'd0);
    chk("rst_rdata",   {32'd0, bus.rdata}, 64'd0);
    chk("rst_addr",    {32'd0, bus.mem_addr}, 64'd0);
    chk("rst_ack_err", {61'd0, bus.ack0, bus.ack1, bus.err}, 64'd0);
    rst_n = 1'b1;
    step(1);

    // Reset mid-BUSY: requester 1 granted, then asynchronous reset drops it.
    bus.req1 = 1; bus.addr1 = 32'h44;
    step(1);
    chk("pre_rst_busy", {62'd0, bus.mem_req, bus.sel}, 64'd3);
    bus.req1 = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", {59'd0, bus.mem_req, bus.sel, bus.ack0, bus.ack1, bus.busy}, 64'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Contention: first tie to requester 0, then strict alternation, ack every 3 cycles.
    bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
    bus.mem_rdy = 1; bus.mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 4; i++) push(i[0], 1'b0, 32'h1111_2222);
    step(1);
    chk("tie_first_sel", {63'd0, bus.sel}, 64'd0);
    base = 0; prev = -1; seen = 0;
    for (cyc = 0; cyc < 40 && base < 4; cyc++) begin
      if (bus.ack0 || bus.ack1) begin
        if (prev >= 0) chk("ack_gap", 64'(cyc - prev), 64'd3);
        prev = cyc;
        base++;
        if (base == 4) begin
          bus.req0 = 0; bus.req1 = 0;
        end
      end
      if (base < 4) step(1);
    end
    chk("contention_done", 64'(base), 64'd4);
    bus.mem_rdy = 0;
    step(2);

    // Single read on requester 0.
    bus.req0 = 1; bus.addr0 = 32'h10; bus.we0 = 0;
    bus.mem_rdy = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    step(1);
    chk("rd_addr", {32'd0, bus.mem_addr}, 64'h10);
    chk("rd_sel",  {63'd0, bus.sel}, 64'd0);
    chk("rd_req",  {63'd0, bus.mem_req}, 64'd1);
    step(1);
    chk("rd_ack",   {62'd0, bus.ack0, bus.err}, 64'd2);
    chk("rd_rdata", {32'd0, bus.rdata}, 64'hDEAD_BEEF);
    bus.req0 = 0; bus.mem_rdy = 0;
    step(1);
    chk("rd_ack_low", {62'd0, bus.ack0, bus.busy}, 64'd0);

    // Write on requester 1; inputs changed mid-BUSY must be ignored.
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h20; bus.wdata1 = 32'h5A5A_5A5A;
    bus.mem_rdata = 32'hCAFE_F00D;
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    step(1);
    bus.addr1 = 32'h99; bus.wdata1 = 32'h0; bus.we1 = 0;
    step(1);
    chk("wr_addr",  {32'd0, bus.mem_addr}, 64'h20);
    chk("wr_wdata", {32'd0, bus.mem_wdata}, 64'h5A5A_5A5A);
    chk("wr_we",    {62'd0, bus.mem_we, bus.sel}, 64'd3);
    bus.mem_rdy = 1;
    step(1);
    chk("wr_ack",   {62'd0, bus.ack1, bus.ack0}, 64'd2);
    chk("wr_rdata_hold", {32'd0, bus.rdata}, 64'hDEAD_BEEF);
    bus.req1 = 0; bus.mem_rdy = 0;
    step(2);

    // Timeout on requester 0: exactly 15 cycles of mem_req, then err.
    bus.req0 = 1; bus.addr0 = 32'h30; bus.we0 = 0;
    push(1'b0, 1'b1, 32'hDEAD_BEEF);
    step(1);
    cnt_req = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.ack0) begin
        seen = 1;
        chk("tmo_err", {63'd0, bus.err}, 64'd1);
        bus.req0 = 0;
      end else begin
        if (bus.mem_req) cnt_req++;
        step(1);
      end
    end
    chk("tmo_seen", {63'd0, seen}, 64'd1);
    chk("tmo_len",  64'(cnt_req), 64'd15);
    step(2);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h40;
    bus.mem_rdy = 1; bus.mem_rdata = 32'h1234_5678;
    push(1'b1, 1'b0, 32'h1234_5678);
    step(2);
    chk("post_tmo_ack1", {62'd0, bus.ack1, bus.err}, 64'd2);
    bus.req1 = 0; bus.mem_rdy = 0;
    step(2);

    // Held request: no grant in ACK, re-grant in the following IDLE cycle.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h50;
    bus.mem_rdy = 1; bus.mem_rdata = 32'h0000_A5A5;
    push(1'b0, 1'b0, 32'h0000_A5A5);
    push(1'b0, 1'b0, 32'h0000_A5A5);
    step(2);
    chk("held_ack", {63'd0, bus.ack0}, 64'd1);
    step(1);
    chk("held_no_grant", {62'd0, bus.mem_req, bus.busy}, 64'd0);
    step(1);
    chk("held_regrant", {62'd0, bus.mem_req, bus.sel}, 64'd2);
    step(1);
    chk("held_ack2", {63'd0, bus.ack0}, 64'd1);
    bus.req0 = 0; bus.mem_rdy = 0;
    step(3);

    chk("sb_drain", 64'(q.size()), 64'd0);
    chk("ack_total", 64'(n_ack), 64'd10);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
